// File: rtl/trap_ctrl.sv
// Trap sequencer: detects illegal/ecall/mret/ebreak and drives the mepc/mcause
// writes, the PC redirect and the sticky halt indication.
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [63:0] pc,
  input  logic        illegal,
  input  logic        is_ecall,
  input  logic        is_mret,
  input  logic        is_ebreak,
  input  logic [63:0] mtvec,
  input  logic [63:0] mepc,
  output logic        stall,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [63:0] csr_wdata,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        halt,
  output logic [31:0] trap_cnt
);

  localparam logic [11:0] AddrMepc   = 12'h341;
  localparam logic [11:0] AddrMcause = 12'h342;

  typedef enum logic [2:0] {
    StIdle,
    StSaveEpc,
    StSaveCause,
    StRedirect,
    StHalt
  } state_e;

  state_e      state_q;
  logic [63:0] epc_q;
  logic [63:0] cause_q;
  logic [63:0] ret_pc_q;
  logic        is_ret_q;
  logic [31:0] trap_cnt_q;
  logic        event_det;

  assign event_det = (state_q == StIdle) && inst_valid &&
                     (illegal || is_ecall || is_mret || is_ebreak);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      epc_q      <= '0;
      cause_q    <= '0;
      ret_pc_q   <= '0;
      is_ret_q   <= 1'b0;
      trap_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (inst_valid) begin
            // Priority: illegal > ebreak > ecall > mret
            if (illegal) begin
              epc_q    <= pc;
              cause_q  <= 64'd2;
              is_ret_q <= 1'b0;
              state_q  <= StSaveEpc;
            end else if (is_ebreak) begin
              state_q <= StHalt;
            end else if (is_ecall) begin
              epc_q    <= pc;
              cause_q  <= 64'd11;
              is_ret_q <= 1'b0;
              state_q  <= StSaveEpc;
            end else if (is_mret) begin
              ret_pc_q <= mepc;
              is_ret_q <= 1'b1;
              state_q  <= StRedirect;
            end
          end
        end
        StSaveEpc:   state_q <= StSaveCause;
        StSaveCause: state_q <= StRedirect;
        StRedirect: begin
          if (!is_ret_q) trap_cnt_q <= trap_cnt_q + 32'd1;
          state_q <= StIdle;
        end
        StHalt:      state_q <= StHalt;
        default:     state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    stall          = 1'b0;
    csr_wen        = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    trap_cnt       = '0;
    if (!rst) begin
      stall    = event_det || (state_q != StIdle);
      halt     = (state_q == StHalt);
      trap_cnt = trap_cnt_q;
      unique case (state_q)
        StSaveEpc: begin
          csr_wen   = 1'b1;
          csr_waddr = AddrMepc;
          csr_wdata = epc_q;
        end
        StSaveCause: begin
          csr_wen   = 1'b1;
          csr_waddr = AddrMcause;
          csr_wdata = cause_q;
        end
        StRedirect: begin
          redirect_valid = 1'b1;
          // Trap vector is live mtvec with the mode bits cleared
          redirect_pc    = is_ret_q ? ret_pc_q : (mtvec & ~64'h3);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port inst_valid  input  1  current instruction is valid this cycle.
REQ-004 SHALL have port pc  input  64  PC of current instruction.
REQ-005 SHALL have port illegal  input  1  decoder flagged instruction as unknown.
REQ-006 SHALL have port is_ecall  input  1  current instruction is ecall.
REQ-007 SHALL have port is_mret  input  1  current instruction is mret.
REQ-008 SHALL have port is_ebreak  input  1  current instruction is ebreak.
REQ-009 SHALL have port mtvec  input  64  current mtvec CSR value.
REQ-010 SHALL have port mepc  input  64  current mepc CSR value.
REQ-011 SHALL have port stall  output  1  freeze fetch, decode and regfile writeback.
REQ-012 SHALL have port csr_wen  output  1  CSR write strobe.
REQ-013 SHALL have port csr_waddr  output  12  CSR address: 0x341 mepc, 0x342 mcause.
REQ-014 SHALL have port csr_wdata  output  64  CSR write data.
REQ-015 SHALL have port redirect_valid  output  1  one-cycle PC redirect strobe.
REQ-016 SHALL have port redirect_pc  output  64  redirect target.
REQ-017 SHALL have port halt  output  1  sticky, simulation-end indication.
REQ-018 SHALL have port trap_cnt  output  32  count of traps taken.

Function
REQ-019 SHALL implement FSM states IDLE, SAVE_EPC, SAVE_CAUSE, REDIRECT, HALT.
REQ-020 SHALL detect an event in IDLE only when inst_valid=1; flags with inst_valid=0 are ignored.
REQ-021 SHALL resolve simultaneous flags by priority: illegal > ebreak > ecall > mret.
REQ-022 SHALL, on illegal or ecall in IDLE, latch pc and cause (illegal=2, ecall=11, zero-extended to 64), then go to SAVE_EPC.
REQ-023 SHALL, in SAVE_EPC, assert csr_wen=1, csr_waddr=0x341, csr_wdata=latched pc, then go to SAVE_CAUSE.
REQ-024 SHALL, in SAVE_CAUSE, assert csr_wen=1, csr_waddr=0x342, csr_wdata=latched cause, then go to REDIRECT.
REQ-025 SHALL, in REDIRECT, assert redirect_valid=1 for exactly one cycle, redirect_pc={mtvec[63:2],2'b00} sampled that cycle, increment trap_cnt, then return to IDLE.
REQ-026 SHALL, on mret in IDLE, latch mepc and go directly to REDIRECT with redirect_pc=latched mepc; no CSR write; trap_cnt unchanged.
REQ-027 SHALL, on ebreak in IDLE, go to HALT; HALT is absorbing until rst; halt=1 from the first HALT cycle.
REQ-028 SHALL drive stall=1 combinationally in the detection cycle (IDLE, inst_valid, any flag) and in every non-IDLE state.
REQ-029 SHALL drive stall=0 in IDLE when no event is detected.
REQ-030 SHALL drive csr_wen=0 and redirect_valid=0 in all states and cycles not listed in REQ-023 to REQ-026.
REQ-031 SHALL ignore all event flags while not in IDLE; events are never queued.
REQ-032 SHALL give trap latency of 3 cycles from detection edge to redirect_valid (SAVE_EPC, SAVE_CAUSE, REDIRECT) and mret latency of 1 cycle.
REQ-033 SHALL wrap trap_cnt from 0xFFFFFFFF to 0 without saturation or flag.
REQ-034 SHALL drive csr_waddr=0 and csr_wdata=0 when csr_wen=0.
REQ-035 SHALL drive redirect_pc=0 when redirect_valid=0.

Reset
REQ-036 SHALL, when rst=1 at a rising edge, enter IDLE, clear latched pc, cause and mepc, and clear trap_cnt and halt.
REQ-037 SHALL abort any in-flight sequence (including HALT) on rst, with no further csr_wen or redirect_valid.
REQ-038 SHALL drive all outputs to 0 while rst=1, including stall.

Verification
REQ-039 SHALL cover this illegal trap: pc=0x80000010, illegal=1, mtvec=0x80000103 -> csr_wen to 0x341 with data 0x80000010, then csr_wen to 0x342 with data 2, then redirect_pc=0x80000100; trap_cnt=1.
REQ-040 SHALL cover this mret: is_mret=1, mepc=0x80000014 -> next cycle redirect_valid=1, redirect_pc=0x80000014; no csr_wen; stall high for 2 cycles total.
REQ-041 SHALL cover this priority case: illegal=1 and is_ecall=1 together -> mcause write data 2; a second ecall during SAVE_CAUSE is ignored.
REQ-042 SHALL cover this halt case: is_ebreak=1 -> halt=1 and stall=1 held for 100 cycles; rst pulse -> halt=0, stall=0, state IDLE.
REQ-043 SHALL cover this wrap case: trap_cnt preloaded near 0xFFFFFFFF by running traps, or forced -> the next ecall wraps it to 0.
REQ-044 SHALL cover reset mid-trap: rst during SAVE_CAUSE -> no redirect_valid follows, trap_cnt=0.
